// File: rtl/gate_prim_pkg.sv
// Shared constants for the gate primitive bank: gate fan-ins, mux ways and select width.
package gate_prim_pkg;

  localparam int unsigned AND_FANIN = 4;
  localparam int unsigned OR_FANIN  = 8;
  localparam int unsigned MUX_WAYS  = 8;
  localparam int unsigned SEL_W     = 3;

endpackage

// File: rtl/gate_and4.sv
// 1-bit 4-input AND leaf cell.
module gate_and4
  import gate_prim_pkg::*;
(
  input  logic [AND_FANIN-1:0] a_i,
  output logic                 y_o
);

  assign y_o = &a_i;

endmodule

// File: rtl/gate_inv.sv
// 1-bit inverter leaf cell.
module gate_inv (
  input  logic a_i,
  output logic y_o
);

  assign y_o = ~a_i;

endmodule

// File: rtl/gate_mux8.sv
// One-lane 8:1 sum-of-products mux built only from INV, AND4 and OR8 cells.
module gate_mux8
  import gate_prim_pkg::*;
(
  input  logic [MUX_WAYS-1:0] d_i,
  input  logic [SEL_W-1:0]    sel_i,
  output logic                y_o
);

  logic [SEL_W-1:0]    sel_n;
  logic [MUX_WAYS-1:0] term;

  for (genvar b = 0; b < SEL_W; b++) begin : g_sel_inv
    gate_inv u_inv (.a_i(sel_i[b]), .y_o(sel_n[b]));
  end

  // Term k ANDs its data bit with the true/complement select literals matching k's code.
  for (genvar k = 0; k < MUX_WAYS; k++) begin : g_term
    localparam logic [SEL_W-1:0] CODE = SEL_W'(k);
    logic [AND_FANIN-1:0] ops;
    assign ops = {CODE[2] ? sel_i[2] : sel_n[2],
                  CODE[1] ? sel_i[1] : sel_n[1],
                  CODE[0] ? sel_i[0] : sel_n[0],
                  d_i[k]};
    gate_and4 u_and (.a_i(ops), .y_o(term[k]));
  end

  gate_or8 u_or (.a_i(term), .y_o(y_o));

endmodule

// File: rtl/gate_or8.sv
// 1-bit 8-input OR leaf cell.
module gate_or8
  import gate_prim_pkg::*;
(
  input  logic [OR_FANIN-1:0] a_i,
  output logic                y_o
);

  assign y_o = |a_i;

endmodule

// File: rtl/gate_prim_bank.sv
// Registered bank of INV / AND4 / OR8 gates and a structural 8:1 mux, bitwise over WIDTH lanes.
module gate_prim_bank
  import gate_prim_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [WIDTH-1:0]          inv_a,
  input  logic [AND_FANIN*WIDTH-1:0] and_in,
  input  logic [OR_FANIN*WIDTH-1:0]  or_in,
  input  logic [SEL_W-1:0]          mux_sel,
  input  logic [MUX_WAYS*WIDTH-1:0]  mux_in,
  output logic [WIDTH-1:0]          inv_y,
  output logic [WIDTH-1:0]          and_y,
  output logic [WIDTH-1:0]          or_y,
  output logic [WIDTH-1:0]          mux_y,
  output logic                      valid
);

  logic [WIDTH-1:0] inv_d, and_d, or_d, mux_d;
  logic [WIDTH-1:0] inv_q, and_q, or_q, mux_q;
  logic             valid_q;

  // Operand k of lane j lives at bit k*WIDTH+j; regroup per lane before feeding the cells.
  for (genvar j = 0; j < WIDTH; j++) begin : g_lane
    logic [AND_FANIN-1:0] and_bits;
    logic [OR_FANIN-1:0]  or_bits;
    logic [MUX_WAYS-1:0]  mux_bits;

    for (genvar k = 0; k < AND_FANIN; k++) begin : g_and_bits
      assign and_bits[k] = and_in[k*WIDTH+j];
    end
    for (genvar k = 0; k < OR_FANIN; k++) begin : g_or_bits
      assign or_bits[k] = or_in[k*WIDTH+j];
    end
    for (genvar k = 0; k < MUX_WAYS; k++) begin : g_mux_bits
      assign mux_bits[k] = mux_in[k*WIDTH+j];
    end

    gate_inv  u_inv (.a_i(inv_a[j]), .y_o(inv_d[j]));
    gate_and4 u_and (.a_i(and_bits), .y_o(and_d[j]));
    gate_or8  u_or  (.a_i(or_bits),  .y_o(or_d[j]));
    gate_mux8 u_mux (.d_i(mux_bits), .sel_i(mux_sel), .y_o(mux_d[j]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_q   <= '0;
      and_q   <= '0;
      or_q    <= '0;
      mux_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      inv_q   <= inv_d;
      and_q   <= and_d;
      or_q    <= or_d;
      mux_q   <= mux_d;
      valid_q <= 1'b1;
    end
  end

  assign inv_y = inv_q;
  assign and_y = and_q;
  assign or_y  = or_q;
  assign mux_y = mux_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_gate_prim_bank.sv
// Directed self-checking bench for gate_prim_bank with four lanes.
module tb_gate_prim_bank;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n, en;
  logic [W-1:0]   inv_a;
  logic [4*W-1:0] and_in;
  logic [8*W-1:0] or_in;
  logic [2:0]     mux_sel;
  logic [8*W-1:0] mux_in;
  logic [W-1:0]   inv_y, and_y, or_y, mux_y;
  logic           valid;

  int tests = 0;
  int fails = 0;

  gate_prim_bank #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inv_a(inv_a), .and_in(and_in),
    .or_in(or_in), .mux_sel(mux_sel), .mux_in(mux_in), .inv_y(inv_y),
    .and_y(and_y), .or_y(or_y), .mux_y(mux_y), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Lane j of mux input k takes bit k of pattern pj.
  function automatic logic [8*W-1:0] pack_mux(input logic [7:0] p0, input logic [7:0] p1,
                                               input logic [7:0] p2, input logic [7:0] p3);
    logic [8*W-1:0] r;
    for (int k = 0; k < 8; k++) begin
      r[k*W+0] = p0[k];
      r[k*W+1] = p1[k];
      r[k*W+2] = p2[k];
      r[k*W+3] = p3[k];
    end
    return r;
  endfunction

  logic [3:0] c4;
  logic [W-1:0] exp_mux0 [8] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1};

  initial begin
    // Reset held two edges with en=1 and all inputs high.
    rst_n = 1'b0; en = 1'b1; inv_a = '1; and_in = '1; or_in = '1; mux_sel = 3'd7; mux_in = '1;
    step(); step();
    chk("rst_inv", inv_y, 4'h0);
    chk("rst_and", and_y, 4'h0);
    chk("rst_or", or_y, 4'h0);
    chk("rst_mux", mux_y, 4'h0);
    chk("rst_valid", W'(valid), 4'h0);

    rst_n = 1'b1; inv_a = '0;
    step();
    chk("rel_inv", inv_y, 4'hF);
    chk("rel_and", and_y, 4'hF);
    chk("rel_or", or_y, 4'hF);
    chk("rel_mux", mux_y, 4'hF);
    chk("rel_valid", W'(valid), 4'h1);

    // AND4 sweep: operand k is bit k of c replicated on every lane.
    for (int c = 0; c < 16; c++) begin
      c4 = 4'(c);
      and_in = {{W{c4[3]}}, {W{c4[2]}}, {W{c4[1]}}, {W{c4[0]}}};
      inv_a = c4;
      step();
      chk($sformatf("and4_c%0d", c), and_y, (c == 15) ? 4'hF : 4'h0);
      chk($sformatf("inv_c%0d", c), inv_y, ~c4);
    end
    and_in = {4'h5, 4'hF, 4'hF, 4'hF};
    step();
    chk("and4_lanes", and_y, 4'h5);

    // OR8: all-zero, then a single 1 walked across every operand bit.
    or_in = '0;
    step();
    chk("or8_zero", or_y, 4'h0);
    for (int i = 0; i < 8*W; i++) begin
      or_in = '0;
      or_in[i] = 1'b1;
      step();
      chk($sformatf("or8_bit%0d", i), or_y, 4'(1 << (i % W)));
    end

    // MUX8 select sweep; lane0 1010_0110, lane1 its complement, lane2 F0, lane3 0F.
    mux_in = pack_mux(8'b1010_0110, 8'b0101_1001, 8'hF0, 8'h0F);
    for (int s = 0; s < 8; s++) begin
      mux_sel = 3'(s);
      step();
      chk($sformatf("mux_sel%0d", s), mux_y,
          {(s < 4) ? 1'b1 : 1'b0, (s >= 4) ? 1'b1 : 1'b0, ~exp_mux0[s][0], exp_mux0[s][0]});
    end

    // Select and data change together: only the new pair matters.
    mux_sel = 3'd5; mux_in = pack_mux(8'h20, 8'h00, 8'hDF, 8'hFF);
    step();
    chk("mux_pair_a", mux_y, 4'b1001);
    mux_sel = 3'd2; mux_in = pack_mux(8'h00, 8'h04, 8'h04, 8'hFB);
    step();
    chk("mux_pair_b", mux_y, 4'b0110);

    // Enable hold.
    mux_sel = 3'd3; mux_in = '1; inv_a = 4'h3; and_in = '1; or_in = '0;
    step();
    chk("hold_cap_mux", mux_y, 4'hF);
    en = 1'b0; inv_a = 4'hC; and_in = '0; or_in = '1; mux_in = '0; mux_sel = 3'd0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("hold_mux%0d", n), mux_y, 4'hF);
      chk($sformatf("hold_inv%0d", n), inv_y, 4'hC);
      chk($sformatf("hold_and%0d", n), and_y, 4'hF);
      chk($sformatf("hold_or%0d", n), or_y, 4'h0);
      chk($sformatf("hold_valid%0d", n), W'(valid), 4'h1);
    end

    // Reset mid-stream overrides en and discards the in-flight sample.
    en = 1'b1; or_in = '1;
    step();
    chk("mid_or_cap", or_y, 4'hF);
    rst_n = 1'b0;
    step();
    chk("mid_or", or_y, 4'h0);
    chk("mid_inv", inv_y, 4'h0);
    chk("mid_valid", W'(valid), 4'h0);
    rst_n = 1'b1; en = 1'b0;
    step();
    chk("post_rst_noen_valid", W'(valid), 4'h0);
    chk("post_rst_noen_or", or_y, 4'h0);
    en = 1'b1;
    step();
    chk("post_rst_en_valid", W'(valid), 4'h1);
    chk("post_rst_en_or", or_y, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_prim_bank.md
# gate_prim_bank

Registered bank of the three basic gate primitives (INV, AND4, OR8), bitwise over a WIDTH-bit vector, plus an 8:1 sum-of-products multiplexer built only from those primitives. It is the clocked gate-level leaf library used by structural datapath blocks such as the full-adder and 8:1 mux stages. It lets those cells be exercised and timed in a synchronous pipeline.

## Interface
Parameters:
- WIDTH, 1, bit-lanes per operand; every gate acts bitwise per lane.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  capture enable; registers update only when 1.
- inv_a  input  WIDTH  INV operand.
- and_in  input  4*WIDTH  AND4 operands; operand k = and_in[k*WIDTH +: WIDTH], k=0..3.
- or_in  input  8*WIDTH  OR8 operands; operand k = or_in[k*WIDTH +: WIDTH], k=0..7.
- mux_sel  input  3  mux select s[2:0].
- mux_in  input  8*WIDTH  mux data; input k = mux_in[k*WIDTH +: WIDTH].
- inv_y  output  WIDTH  registered ~inv_a.
- and_y  output  WIDTH  registered AND of the four and_in operands.
- or_y  output  WIDTH  registered OR of the eight or_in operands.
- mux_y  output  WIDTH  registered mux_in operand selected by mux_sel.
- valid  output  1  1 when the output registers hold a result captured with en=1.

## Operation
- INV: inv_y = ~inv_a per bit.
- AND4: and_y = op0 & op1 & op2 & op3 per bit.
- OR8: or_y = OR of op0..op7 per bit.
- MUX8: structural sum-of-products, no behavioural case statement.
  - Three INV cells produce ~s[0], ~s[1], ~s[2].
  - Eight AND4 cells per lane form term k = in_k & (s2 or ~s2) & (s1 or ~s1) & (s0 or ~s0), matching k's binary code.
  - One OR8 cell merges the eight terms.
  - Result: mux_y = mux_in operand number mux_sel. Exactly one term can be nonzero.
- All four results are computed combinationally from the current inputs.
- They are captured together into the output registers when en=1.
- With en=0, every output register and valid hold their value.
- No X-propagation handling is required beyond standard RTL semantics.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Throughput: one result per cycle while en=1.
- Reset: on a rising clk edge with rst_n=0, inv_y, and_y, or_y, mux_y and valid all go to 0.
  - Reset overrides en.
  - Reset asserted mid-stream discards the in-flight sample.
  - The first capture after reset release occurs on the first edge with rst_n=1 and en=1.
- valid:
  - Set to 1 on any capture edge.
  - Cleared only by reset.
  - Holds when en=0.
- Simultaneous changes of mux_sel and mux_in in one cycle produce the result for the new pair only. There is no glitch on the registered output.
- No asynchronous paths. Outputs are purely registered.

## Structure
- Shared package gate_prim_pkg holds:
  - the lane-slicing helper constants: AND_FANIN=4, OR_FANIN=8, MUX_WAYS=8;
  - the select-width constant SEL_W=3.
- Natural sub-modules are the leaf combinational cells gate_inv, gate_and4 and gate_or8, each 1 bit.
  - They are generated per lane, using the same cells for the standalone gates and inside the mux.
- gate_mux8 is an optional named wrapper around the INV/AND4/OR8 netlist for one lane.
- Top level contains only the generate loops, the en-gated capture registers and valid.

## Test plan
- Reset: rst_n=0 for 2 cycles with en=1 and all inputs 1 -> all outputs 0, valid=0. Release with inv_a=0 -> next cycle inv_y=all-ones, valid=1.
- AND4 sweep, WIDTH=1: drive all 16 combinations of and_in.
  - Expect and_y=1 only for and_in=4'b1111, one cycle later.
  - Also check inv_y tracks ~inv_a for 0 and 1.
- OR8 sweep: drive or_in=0 -> or_y=0. Walk a single 1 through bits 0..7 -> or_y=1 each cycle.
- MUX8, WIDTH=1, mux_in=8'b1010_0110, mux_sel stepping 0..7:
  - Expect mux_y sequence 0,1,1,0,0,1,0,1, each one cycle after its select.
- Enable hold: capture mux_sel=3 with mux_in=8'hFF (mux_y=1), then en=0 while changing all inputs -> outputs frozen and valid=1 for 3 cycles.
- Reset mid-stream, WIDTH=4: capture or_y=4'hF, then assert rst_n=0 for one edge with en=1 -> outputs 0 and valid=0 on that edge.
